// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 64-bit memory port between IFU fetch and LSU load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_rdata,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_rdata,
    output logic        lsu_resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             own_lsu;
    logic [63:0]      addr_q;
    logic [63:0]      wdata_q;
    logic [7:0]       wmask_q;
    logic             wen_q;
    logic [63:0]      rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       shamt;
    logic             grant_ifu;
    logic             grant_lsu;
    logic             accept;
    logic             timeout;

`ifdef MEM_ARB_RR_EN
    logic last_lsu;

    // on contention, the requester not granted last time wins
    always_comb begin
        grant_lsu = lsu_req_valid && !(ifu_req_valid && last_lsu);
        grant_ifu = ifu_req_valid && !grant_lsu;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last_lsu <= 1'b0;
        else if (accept)
            last_lsu <= grant_lsu;
    end
`else
    assign grant_lsu = lsu_req_valid;
    assign grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif

    assign accept  = (state == IDLE) && (grant_ifu || grant_lsu);
    assign timeout = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);
    assign shamt   = {addr_q[2:0], 3'b000};

    assign mem_addr  = {addr_q[63:3], 3'b000};
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q << shamt;
    assign mem_wmask = wen_q ? (wmask_q << addr_q[2:0]) : 8'h00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = 64'h0;
        lsu_rdata      = 64'h0;
        ifu_resp_err   = 1'b0;
        lsu_resp_err   = 1'b0;
        unique case (state)
            IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_ifu || grant_lsu)
                    state_nxt = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid || timeout)
                    state_nxt = RESP;
            end
            RESP: begin
                ifu_resp_valid = !own_lsu;
                lsu_resp_valid = own_lsu;
                ifu_rdata      = own_lsu ? 64'h0 : rdata_q;
                lsu_rdata      = own_lsu ? rdata_q : 64'h0;
                ifu_resp_err   = !own_lsu && err_q;
                lsu_resp_err   = own_lsu && err_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            own_lsu <= 1'b0;
            addr_q  <= 64'h0;
            wdata_q <= 64'h0;
            wmask_q <= 8'h00;
            wen_q   <= 1'b0;
            rdata_q <= 64'h0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        own_lsu <= grant_lsu;
                        addr_q  <= grant_lsu ? lsu_addr : ifu_addr;
                        wen_q   <= grant_lsu && lsu_wen;
                        wdata_q <= grant_lsu ? lsu_wdata : 64'h0;
                        wmask_q <= grant_lsu ? lsu_wmask : 8'hFF;
                    end
                end
                REQ: begin
                    if (mem_req_ready)
                        cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // a response arriving on the timeout cycle still wins
                    if (mem_resp_valid) begin
                        rdata_q <= wen_q ? 64'h0 : (mem_rdata >> shamt);
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= 64'h0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of capture, alignment, arbitration,
// back-pressure, timeout and mid-transaction reset.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [63:0] ifu_rdata;
    logic        ifu_resp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [63:0] lsu_addr;
    logic        lsu_wen;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [63:0] lsu_rdata;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clock = ~clock;

    mem_arbiter #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic exp_l;
        reset          = 1'b1;
        ifu_req_valid  = 1'b0;
        ifu_addr       = 64'h0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = 64'h0;
        lsu_wen        = 1'b0;
        lsu_wdata      = 64'h0;
        lsu_wmask      = 8'h00;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 64'h0;
        step();
        step();
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
        chk1("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
        chk64("rst_mem_addr", mem_addr, 64'h0);
        chk64("rst_mem_wmask", 64'(mem_wmask), 64'h0);
        chk1("rst_mem_wen", mem_wen, 1'b0);
        reset = 1'b0;
        step();

        // IFU read, offset 4, zero-wait memory
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0004;
        #1;
        chk1("t1_ifu_ready", ifu_req_ready, 1'b1);
        chk1("t1_lsu_ready", lsu_req_ready, 1'b0);
        chk1("t1_no_req_idle", mem_req_valid, 1'b0);
        step();
        ifu_req_valid = 1'b0;
        chk1("t1_mem_req_valid", mem_req_valid, 1'b1);
        chk64("t1_mem_addr", mem_addr, 64'h8000_0000);
        chk1("t1_mem_wen", mem_wen, 1'b0);
        chk64("t1_mem_wmask", 64'(mem_wmask), 64'h0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h1122_3344_5566_7788;
        chk1("t1_wait_no_req", mem_req_valid, 1'b0);
        chk1("t1_no_early_resp", ifu_resp_valid, 1'b0);
        step();
        mem_resp_valid = 1'b0;
        chk1("t1_ifu_resp_valid", ifu_resp_valid, 1'b1);
        chk64("t1_ifu_rdata", ifu_rdata, 64'h0000_0000_1122_3344);
        chk1("t1_ifu_err", ifu_resp_err, 1'b0);
        chk1("t1_lsu_resp_quiet", lsu_resp_valid, 1'b0);
        step();
        chk1("t1_resp_one_cycle", ifu_resp_valid, 1'b0);

        // LSU byte write at offset 3
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_0103;
        lsu_wen       = 1'b1;
        lsu_wdata     = 64'hAB;
        lsu_wmask     = 8'h01;
        #1;
        chk1("t2_lsu_ready", lsu_req_ready, 1'b1);
        step();
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        chk64("t2_mem_addr", mem_addr, 64'h8000_0100);
        chk1("t2_mem_wen", mem_wen, 1'b1);
        chk64("t2_mem_wmask", 64'(mem_wmask), 64'h08);
        chk64("t2_mem_wdata", mem_wdata, 64'hAB00_0000);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        mem_resp_valid = 1'b0;
        chk1("t2_lsu_resp_valid", lsu_resp_valid, 1'b1);
        chk64("t2_lsu_rdata_zero", lsu_rdata, 64'h0);
        chk1("t2_ifu_resp_quiet", ifu_resp_valid, 1'b0);
        step();

        // contention: 4 back-to-back rounds from a fresh reset
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0300;
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_0200;
        lsu_wen       = 1'b0;
        mem_rdata     = 64'h0102_0304_0506_0708;
        for (int r = 0; r < 4; r++) begin
            exp_l = RR ? (r % 2 == 0) : 1'b1;
            #1;
            chk1($sformatf("t3_lsu_ready_r%0d", r), lsu_req_ready, exp_l);
            chk1($sformatf("t3_ifu_ready_r%0d", r), ifu_req_ready, !exp_l);
            step();
            chk64($sformatf("t3_mem_addr_r%0d", r), mem_addr,
                  exp_l ? 64'h8000_0200 : 64'h8000_0300);
            mem_req_ready = 1'b1;
            step();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            step();
            mem_resp_valid = 1'b0;
            chk1($sformatf("t3_lsu_resp_r%0d", r), lsu_resp_valid, exp_l);
            chk1($sformatf("t3_ifu_resp_r%0d", r), ifu_resp_valid, !exp_l);
            chk1($sformatf("t3_no_accept_resp_r%0d", r),
                 lsu_req_ready || ifu_req_ready, 1'b0);
            step();
        end
        lsu_req_valid = 1'b0;
        #1;
        chk1("t3_ifu_after_lsu_drop", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk1("t3_ifu_served", ifu_resp_valid, 1'b1);
        chk64("t3_ifu_rdata", ifu_rdata, 64'h0102_0304_0506_0708);
        step();

        // back-pressure: ready low for 5 REQ cycles
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0010;
        step();
        ifu_req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk1($sformatf("t4_req_held_%0d", k), mem_req_valid, 1'b1);
            chk64($sformatf("t4_addr_held_%0d", k), mem_addr, 64'h8000_0010);
            step();
        end
        mem_req_ready = 1'b1;
        chk1("t4_req_at_hs", mem_req_valid, 1'b1);
        step();
        mem_req_ready = 1'b0;
        chk1("t4_wait_entered", mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hA5A5_5A5A_0F0F_F0F0;
        step();
        mem_resp_valid = 1'b0;
        chk1("t4_ifu_resp", ifu_resp_valid, 1'b1);
        chk64("t4_ifu_rdata", ifu_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
        step();

        // timeout: memory never responds
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_0008;
        lsu_wen       = 1'b0;
        mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk1($sformatf("t5_no_resp_w%0d", k), lsu_resp_valid, 1'b0);
        end
        step();
        chk1("t5_to_resp_valid", lsu_resp_valid, 1'b1);
        chk1("t5_to_err", lsu_resp_err, 1'b1);
        chk64("t5_to_rdata", lsu_rdata, 64'h0);
        step();
        chk1("t5_to_pulse_end", lsu_resp_valid, 1'b0);

        // response on the final timeout cycle wins
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_000A;
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h1122_3344_5566_7788;
        step();
        mem_resp_valid = 1'b0;
        chk1("t5b_resp_valid", lsu_resp_valid, 1'b1);
        chk1("t5b_err_clear", lsu_resp_err, 1'b0);
        chk64("t5b_rdata", lsu_rdata, 64'h0000_1122_3344_5566);
        step();

        // reset while waiting drops the transaction
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0020;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk1("t6_async_req_valid", mem_req_valid, 1'b0);
        chk64("t6_async_mem_addr", mem_addr, 64'h0);
        chk1("t6_async_ifu_resp", ifu_resp_valid, 1'b0);
        step();
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h7777_6666_5555_4444;
        step();
        mem_resp_valid = 1'b0;
        chk1("t6_late_ifu_quiet", ifu_resp_valid, 1'b0);
        chk1("t6_late_lsu_quiet", lsu_resp_valid, 1'b0);
        step();
        chk1("t6_late_ifu_quiet2", ifu_resp_valid, 1'b0);
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0028;
        #1;
        chk1("t6_next_ready", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0;
        chk64("t6_next_addr", mem_addr, 64'h8000_0028);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h0123_4567_89AB_CDEF;
        step();
        mem_resp_valid = 1'b0;
        chk1("t6_next_resp", ifu_resp_valid, 1'b1);
        chk64("t6_next_rdata", ifu_rdata, 64'h0123_4567_89AB_CDEF);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
